bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock.
- Produces the packed BCD digits that drive the 7-segment digit decoders for the clock's hour, minute and alarm fields.
- Uses a start/ready/done handshake so the time-keeping logic can convert a field on demand.
- Holds the last result stable until the next conversion completes.

---
 rtl/bin_to_bcd_seq_pkg.sv | 26 ++
 rtl/bin_to_bcd_seq_add3.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// The optional BIN2BCD_BLANK_EN leading-zero blanking output is enabled in the top module.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_BIN_W = 7;
  localparam int CNT_W     = $clog2(DEF_BIN_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// One double-dabble adjust cell: a digit of 5 or more gets +3 so the next shift
// carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank output.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN2BCD_BLANK_EN
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
`else
  output logic                  overflow
`endif
);

  localparam int SW    = 4 * DIGITS;
  localparam int CW    = cnt_w(BIN_W);
  localparam int LIMIT = pow10(DIGITS);
  localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [BIN_W-1:0]  sreg;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic [SW-1:0]     shifted;
  logic              ovf_flag;
  logic              load;
  logic              last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Carry out of the top digit is dropped; it only occurs when the result saturates.
  assign shifted = {adj[SW-2:0], sreg[BIN_W-1]};
  assign last    = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        sreg     <= bin;
        scratch  <= '0;
        cnt      <= CW'(BIN_W);
        ovf_flag <= (int'(bin) >= LIMIT);
      end else if (state == SHIFT) begin
        scratch <= shifted;
        sreg    <= sreg << 1;
        cnt     <= cnt - CW'(1);
      end
      // Outputs change only here, so partial results never reach bcd.
      if (last) begin
        bcd      <= ovf_flag ? NINES : shifted;
        overflow <= ovf_flag;
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'(1 << (DIGITS - 1)) & ~DIGITS'(1);

  logic [DIGITS-1:0] blank_next;

  always_comb begin
    blank_next = '0;
    blank_next[DIGITS-1] = (shifted[SW-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      blank_next[i] = blank_next[i+1] && (shifted[4*i +: 4] == 4'd0);
    end
    // The units digit always shows, so a value of zero still displays "0".
    blank_next[0] = 1'b0;
    if (ovf_flag) begin
      blank_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= BLANK_RST;
    end else if (last) begin
      blank <= blank_next;
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=7, DIGITS=2).
// Blank checks are compiled in only when BIN2BCD_BLANK_EN is defined.
module tb_bin_to_bcd_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] bin;
  logic       ready;
  logic       done;
  logic [7:0] bcd;
  logic       overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [1:0] blank;
`endif

  int tests_run;
  int tests_failed;

  bin_to_bcd_seq #(.BIN_W(7), .DIGITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .ready    (ready),
    .done     (done),
    .bcd      (bcd),
`ifdef BIN2BCD_BLANK_EN
    .overflow (overflow),
    .blank    (blank)
`else
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge and return how many edges later done was seen (-1 if never).
  task automatic run_conv(input logic [6:0] v, output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    tests_run++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: ready=%b done=%b, want ready=1 done=0", ready, done);
    end
    tests_run++;
    if (bcd !== 8'h00 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: bcd=%h overflow=%b, want bcd=00 overflow=0", bcd, overflow);
    end
`ifdef BIN2BCD_BLANK_EN
    tests_run++;
    if (blank !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_blank: blank=%b, want 10", blank);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_conv(7'd42, lat);
    tests_run++;
    if (lat !== 7) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: done after %0d edges, want 7", lat);
    end
    tests_run++;
    if (bcd !== 8'h42 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_value: bcd=%h overflow=%b, want 42 0", bcd, overflow);
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_ready: ready=%b in done cycle, want 1", ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || bcd !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL basic_pulse: done=%b bcd=%h after done cycle, want 0 42", done, bcd);
    end
  endtask

  task automatic test_values();
    logic [6:0] vals [7]  = '{7'd99, 7'd0, 7'd7, 7'd127, 7'd100, 7'd10, 7'd98};
    logic [7:0] exp_b [7] = '{8'h99, 8'h00, 8'h07, 8'h99, 8'h99, 8'h10, 8'h98};
    logic       exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef BIN2BCD_BLANK_EN
    logic [1:0] exp_k [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
    int lat;
    for (int k = 0; k < 7; k++) begin
      run_conv(vals[k], lat);
      tests_run++;
      if (lat !== 7 || bcd !== exp_b[k]) begin
        tests_failed++;
        $display("[TB] FAIL value_%0d: lat=%0d bcd=%h, want lat=7 bcd=%h", vals[k], lat, bcd, exp_b[k]);
      end
      tests_run++;
      if (overflow !== exp_o[k]) begin
        tests_failed++;
        $display("[TB] FAIL overflow_%0d: overflow=%b, want %b", vals[k], overflow, exp_o[k]);
      end
`ifdef BIN2BCD_BLANK_EN
      tests_run++;
      if (blank !== exp_k[k]) begin
        tests_failed++;
        $display("[TB] FAIL blank_%0d: blank=%b, want %b", vals[k], blank, exp_k[k]);
      end
`endif
    end
  endtask

  task automatic test_ignore_busy();
    int first_done;
    int n_done;
    first_done = -1;
    n_done     = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd13;
    @(posedge clk);
    #1 start = 1'b0;
    bin = 7'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd55;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    tests_run++;
    if (first_done !== 7 || n_done !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ignore_timing: first done at %0d count %0d, want 7 and 1", first_done, n_done);
    end
    tests_run++;
    if (bcd !== 8'h13 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ignore_value: bcd=%h overflow=%b, want 13 0", bcd, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int         e [2];
    logic [7:0] v [2];
    int         n_done;
    e      = '{-1, -1};
    v      = '{8'h00, 8'h00};
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd10;
    @(posedge clk);
    #1 bin = 7'd11;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (n_done < 2) begin
          e[n_done] = i;
          v[n_done] = bcd;
        end
        n_done++;
      end
      if (i == 8) start = 1'b0;
    end
    tests_run++;
    if (n_done !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: %0d done pulses, want 2", n_done);
    end
    tests_run++;
    if (e[0] !== 7 || v[0] !== 8'h10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: edge %0d bcd=%h, want edge 7 bcd=10", e[0], v[0]);
    end
    tests_run++;
    if (e[1] !== 15 || v[1] !== 8'h11) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: edge %0d bcd=%h, want edge 15 bcd=11", e[1], v[1]);
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    int lat;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd59;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_ctrl: ready=%b done=%b, want 1 0", ready, done);
    end
    tests_run++;
    if (bcd !== 8'h00 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_data: bcd=%h overflow=%b, want 00 0", bcd, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    tests_run++;
    if (n_done !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: %0d done pulses after abort, want 0", n_done);
    end
    run_conv(7'd59, lat);
    tests_run++;
    if (lat !== 7 || bcd !== 8'h59) begin
      tests_failed++;
      $display("[TB] FAIL abort_restart: lat=%0d bcd=%h, want 7 59", lat, bcd);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_values();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
